// File: rtl/alert_handler_accu_multi.sv
// Multi-class alert accumulator with optional leaky (decay) mode.
// Each class counts gated triggers in a saturating counter. It raises
// escalation when a trigger arrives while count >= threshold. Counter and
// decay timer are duplicated, and any copy mismatch sets a sticky fault.
//
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   class_en_i      per-class enable
//   clr_i           per-class clear of counter and decay timer
//   class_trig_i    per-class alert trigger pulse
//   thresh_i        per-class escalation threshold (packed, AccuCntDw each)
//   decay_en_i      per-class leaky-mode enable
//   decay_period_i  per-class cycles per decrement, 0 disables decay
//   accu_cnt_o      per-class counter value (copy 0)
//   accu_trig_o     per-class escalation trigger (combinational)
//   accu_sat_o      per-class counter-at-all-ones flag
//   accu_fail_o     per-class sticky redundancy fault
module alert_handler_accu_multi #(
  parameter int unsigned NumClasses = 4,
  parameter int unsigned AccuCntDw  = 16,
  parameter int unsigned DecayDw    = 24
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumClasses-1:0]           class_en_i,
  input  logic [NumClasses-1:0]           clr_i,
  input  logic [NumClasses-1:0]           class_trig_i,
  input  logic [NumClasses*AccuCntDw-1:0] thresh_i,
  input  logic [NumClasses-1:0]           decay_en_i,
  input  logic [NumClasses*DecayDw-1:0]   decay_period_i,
  output logic [NumClasses*AccuCntDw-1:0] accu_cnt_o,
  output logic [NumClasses-1:0]           accu_trig_o,
  output logic [NumClasses-1:0]           accu_sat_o,
  output logic [NumClasses-1:0]           accu_fail_o
);

  for (genvar c = 0; c < NumClasses; c++) begin : g_class
    logic [AccuCntDw-1:0] thresh;
    logic [DecayDw-1:0]   period;
    logic                 trig_g, dec_act, clr;
    logic [AccuCntDw-1:0] cnt0_q, cnt0_d;
    logic [DecayDw-1:0]   tmr0_q, tmr0_d;
    logic                 tick0;
    // Copy-1 input taps, kept as separate nets from copy 0
    logic                 trig_g1, dec_act1, clr1;
    logic [DecayDw-1:0]   period1;
    logic [AccuCntDw-1:0] cnt1_q, cnt1_d;
    logic [DecayDw-1:0]   tmr1_q, tmr1_d;
    logic                 tick1;
    logic                 fail_q;

    assign thresh  = thresh_i[c*AccuCntDw +: AccuCntDw];
    assign period  = decay_period_i[c*DecayDw +: DecayDw];
    assign trig_g  = class_trig_i[c] & class_en_i[c];
    assign dec_act = decay_en_i[c] & class_en_i[c] & (period != '0);
    assign clr     = clr_i[c];

    assign trig_g1  = class_trig_i[c] & class_en_i[c];
    assign dec_act1 = decay_en_i[c] & class_en_i[c] &
                      (decay_period_i[c*DecayDw +: DecayDw] != '0);
    assign clr1     = clr_i[c];
    assign period1  = decay_period_i[c*DecayDw +: DecayDw];

    // Copy 0: decay timer and counter next state
    always_comb begin
      tmr0_d = tmr0_q;
      tick0  = 1'b0;
      cnt0_d = cnt0_q;
      // >= lets a shortened period expire an already-advanced timer at once
      if (clr || !dec_act || (cnt0_q == '0)) begin
        tmr0_d = '0;
      end else if (tmr0_q >= period - DecayDw'(1)) begin
        tmr0_d = '0;
        tick0  = 1'b1;
      end else begin
        tmr0_d = tmr0_q + DecayDw'(1);
      end
      if (clr) begin
        cnt0_d = '0;
      end else if (trig_g && tick0) begin
        cnt0_d = cnt0_q;
      end else if (trig_g) begin
        if (cnt0_q != '1) cnt0_d = cnt0_q + AccuCntDw'(1);
      end else if (tick0) begin
        cnt0_d = cnt0_q - AccuCntDw'(1);
      end
    end

    // Copy 1: independent next-state logic from its own input taps
    always_comb begin
      tmr1_d = tmr1_q;
      tick1  = 1'b0;
      cnt1_d = cnt1_q;
      if (clr1 || !dec_act1 || (cnt1_q == '0)) begin
        tmr1_d = '0;
      end else if (tmr1_q >= period1 - DecayDw'(1)) begin
        tmr1_d = '0;
        tick1  = 1'b1;
      end else begin
        tmr1_d = tmr1_q + DecayDw'(1);
      end
      if (clr1) begin
        cnt1_d = '0;
      end else if (trig_g1 && tick1) begin
        cnt1_d = cnt1_q;
      end else if (trig_g1) begin
        if (cnt1_q != '1) cnt1_d = cnt1_q + AccuCntDw'(1);
      end else if (tick1) begin
        cnt1_d = cnt1_q - AccuCntDw'(1);
      end
    end

    // Copy-0 state
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt0_q <= '0;
        tmr0_q <= '0;
      end else begin
        cnt0_q <= cnt0_d;
        tmr0_q <= tmr0_d;
      end
    end

    // Copy-1 state
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt1_q <= '0;
        tmr1_q <= '0;
      end else begin
        cnt1_q <= cnt1_d;
        tmr1_q <= tmr1_d;
      end
    end

    // Sticky fault: only reset clears it
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        fail_q <= 1'b0;
      end else if ((cnt0_q != cnt1_q) || (tmr0_q != tmr1_q)) begin
        fail_q <= 1'b1;
      end
    end

    assign accu_cnt_o[c*AccuCntDw +: AccuCntDw] = cnt0_q;
    assign accu_trig_o[c] = trig_g & (cnt0_q >= thresh);
    assign accu_sat_o[c]  = &cnt0_q;
    assign accu_fail_o[c] = fail_q;
  end

endmodule

// File: tb/tb_alert_handler_accu_multi.sv
// Self-checking bench for alert_handler_accu_multi: a per-class integer
// model checked every cycle, plus directed literal checks.
module tb_alert_handler_accu_multi;
  localparam int unsigned NC = 4;
  localparam int unsigned CW = 16;
  localparam int unsigned DW = 24;
  localparam longint unsigned CMAX = (64'd1 << CW) - 1;

  logic clk;
  logic rst_ni;
  logic [NC-1:0]    en, clr, trig, den;
  logic [NC*CW-1:0] thresh;
  logic [NC*DW-1:0] period;
  logic [NC*CW-1:0] accu_cnt;
  logic [NC-1:0]    accu_trig, accu_sat, accu_fail;

  logic [0:0] s_en, s_clr, s_trig, s_den;
  logic [3:0] s_thr;
  logic [7:0] s_per;
  logic [3:0] s_cnt;
  logic [0:0] s_atrig, s_sat, s_fail;

  int checks = 0;
  int errors = 0;

  longint unsigned m_cnt [NC];
  longint unsigned m_tmr [NC];
  bit              inj_fail [NC];

  alert_handler_accu_multi #(.NumClasses(NC), .AccuCntDw(CW), .DecayDw(DW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .class_en_i(en), .clr_i(clr),
    .class_trig_i(trig), .thresh_i(thresh), .decay_en_i(den),
    .decay_period_i(period), .accu_cnt_o(accu_cnt), .accu_trig_o(accu_trig),
    .accu_sat_o(accu_sat), .accu_fail_o(accu_fail)
  );

  alert_handler_accu_multi #(.NumClasses(1), .AccuCntDw(4), .DecayDw(8)) u_small (
    .clk_i(clk), .rst_ni(rst_ni), .class_en_i(s_en), .clr_i(s_clr),
    .class_trig_i(s_trig), .thresh_i(s_thr), .decay_en_i(s_den),
    .decay_period_i(s_per), .accu_cnt_o(s_cnt), .accu_trig_o(s_atrig),
    .accu_sat_o(s_sat), .accu_fail_o(s_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Advance n clock edges; inputs change 2 time units after the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_thr(input int c, input int unsigned v);
    thresh[c*CW +: CW] = CW'(v);
  endtask

  task automatic set_per(input int c, input int unsigned v);
    period[c*DW +: DW] = DW'(v);
  endtask

  function automatic logic [63:0] cnt_of(input int c);
    return 64'(accu_cnt[c*CW +: CW]);
  endfunction

  // Model: compare at the falling edge, then advance to the post-edge state
  longint unsigned th, per;
  bit tg, act, tick;
  always @(negedge clk) begin
    if (!rst_ni) begin
      for (int c = 0; c < NC; c++) begin
        m_cnt[c] = 0;
        m_tmr[c] = 0;
      end
      chk("rst_cnt", 64'(accu_cnt), 64'd0);
      chk("rst_trig", 64'(accu_trig), 64'd0);
      chk("rst_sat", 64'(accu_sat), 64'd0);
      chk("rst_fail", 64'(accu_fail), 64'd0);
    end else begin
      for (int c = 0; c < NC; c++) begin
        th  = 64'(thresh[c*CW +: CW]);
        per = 64'(period[c*DW +: DW]);
        tg  = trig[c] & en[c];
        act = den[c] & en[c] & (per != 0);
        chk($sformatf("cnt[%0d]", c), cnt_of(c), m_cnt[c]);
        chk($sformatf("trig[%0d]", c), 64'(accu_trig[c]), 64'(tg && (m_cnt[c] >= th)));
        chk($sformatf("sat[%0d]", c), 64'(accu_sat[c]), 64'(m_cnt[c] == CMAX));
        chk($sformatf("fail[%0d]", c), 64'(accu_fail[c]), 64'(inj_fail[c]));
        tick = 1'b0;
        if (clr[c] || !act || m_cnt[c] == 0) begin
          m_tmr[c] = 0;
        end else if (m_tmr[c] + 1 >= per) begin
          m_tmr[c] = 0;
          tick = 1'b1;
        end else begin
          m_tmr[c] = m_tmr[c] + 1;
        end
        if (clr[c])            m_cnt[c] = 0;
        else if (tg && tick)   m_cnt[c] = m_cnt[c];
        else if (tg)           m_cnt[c] = (m_cnt[c] == CMAX) ? CMAX : m_cnt[c] + 1;
        else if (tick)         m_cnt[c] = m_cnt[c] - 1;
      end
    end
  end

  logic [CW-1:0] flip_val;

  initial begin
    rst_ni = 1'b0;
    en = '0; clr = '0; trig = '0; den = '0; thresh = '0; period = '0;
    s_en = '0; s_clr = '0; s_trig = '0; s_den = '0; s_thr = 4'd15; s_per = '0;
    for (int c = 0; c < NC; c++) inj_fail[c] = 1'b0;
    step(3);
    rst_ni = 1'b1;
    step(1);
    chk("post_rst_cnt0", cnt_of(0), 64'd0);

    // Basic counting and escalation on class 0
    en[0] = 1'b1; set_thr(0, 3); trig[0] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      chk("t1_cnt", cnt_of(0), 64'(i));
    end
    #1 chk("t1_esc", 64'(accu_trig[0]), 64'd1);
    step(1);
    chk("t1_cnt4", cnt_of(0), 64'd4);
    en[0] = 1'b0;
    #1 chk("t1_gated", 64'(accu_trig[0]), 64'd0);
    step(2);
    chk("t1_hold", cnt_of(0), 64'd4);
    trig[0] = 1'b0; en[0] = 1'b1;

    // Saturation on the 4-bit instance
    s_en = 1'b1; s_trig = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step(1);
      chk("t2_cnt", 64'(s_cnt), 64'((i > 15) ? 15 : i));
    end
    chk("t2_sat", 64'(s_sat), 64'd1);
    s_trig = 1'b0;

    // Decay on class 1
    en[1] = 1'b1; set_thr(1, 100); trig[1] = 1'b1;
    step(2);
    trig[1] = 1'b0;
    chk("t3_cnt2", cnt_of(1), 64'd2);
    den[1] = 1'b1; set_per(1, 5);
    step(5);
    chk("t3_dec1", cnt_of(1), 64'd1);
    step(5);
    chk("t3_dec0", cnt_of(1), 64'd0);
    step(3);
    chk("t3_idle", cnt_of(1), 64'd0);
    den[1] = 1'b0; trig[1] = 1'b1;
    step(2);
    trig[1] = 1'b0; den[1] = 1'b1;
    step(4);
    trig[1] = 1'b1;
    step(1);
    trig[1] = 1'b0;
    chk("t3_netzero", cnt_of(1), 64'd2);
    step(5);
    chk("t3_after", cnt_of(1), 64'd1);

    // Clear beats trigger and expiring tick; timer restarts from zero
    step(4);
    clr[1] = 1'b1; trig[1] = 1'b1;
    step(1);
    clr[1] = 1'b0; trig[1] = 1'b0;
    chk("t4_clr", cnt_of(1), 64'd0);
    trig[1] = 1'b1;
    step(1);
    trig[1] = 1'b0;
    step(4);
    chk("t4_restart", cnt_of(1), 64'd1);
    step(1);
    chk("t4_tick", cnt_of(1), 64'd0);
    den[1] = 1'b0;

    // Redundancy fault on class 2
    en[2] = 1'b1; set_thr(2, 50); trig[2] = 1'b1;
    step(1);
    trig[2] = 1'b0;
    step(1);
    flip_val = dut.g_class[2].cnt1_q ^ CW'(1);
    force dut.g_class[2].cnt1_q = flip_val;
    step(1);
    release dut.g_class[2].cnt1_q;
    inj_fail[2] = 1'b1;
    chk("t5_fail", 64'(accu_fail[2]), 64'd1);
    clr[2] = 1'b1;
    step(1);
    clr[2] = 1'b0; en[2] = 1'b0;
    step(2);
    chk("t5_sticky", 64'(accu_fail[2]), 64'd1);
    chk("t5_others", 64'(accu_fail & 4'b1011), 64'd0);

    // Concurrent classes with different rates, thresholds and decay
    en = '1; clr = '0;
    set_thr(0, 2); set_thr(1, 5); set_thr(2, 0); set_thr(3, 9);
    den = 4'b1100; set_per(2, 3); set_per(3, 7);
    for (int cyc = 0; cyc < 150; cyc++) begin
      for (int c = 0; c < NC; c++) trig[c] = ((cyc % (c + 2)) == 0);
      clr[0] = (cyc == 80);
      en[1]  = !(cyc >= 40 && cyc < 60);
      if (cyc == 100) set_per(3, 2);
      step(1);
    end
    trig = '0; clr = '0;
    step(3);

    // Reset mid-operation clears everything, including the sticky fault
    trig = 4'b1111;
    rst_ni = 1'b0;
    for (int c = 0; c < NC; c++) inj_fail[c] = 1'b0;
    #1;
    chk("rst_mid_cnt", 64'(accu_cnt), 64'd0);
    chk("rst_mid_fail", 64'(accu_fail), 64'd0);
    trig = '0;
    step(2);
    rst_ni = 1'b1;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
